// File: rtl/resp_pkg.sv
// Shared definitions for the UART response framer: frame type codes, FSM
// encoding and the byte-select helper used to serialize a response frame.
package resp_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'h55;
  localparam int         RD_LEN      = 4;
  localparam int         WR_LEN      = 3;

  typedef enum logic [1:0] {
    RSP_RD = 2'b00,
    RSP_WR = 2'b10
  } rsp_type_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    FINISH    = 3'd5
  } resp_state_e;

  typedef struct packed {
    rsp_type_e   typ;
    logic [5:0]  addr;
    logic [7:0]  data;
  } rsp_frame_t;

  function automatic logic [1:0] last_idx(input rsp_type_e t);
    return (t == RSP_RD) ? 2'(RD_LEN - 1) : 2'(WR_LEN - 1);
  endfunction

  // Byte idx of a frame; write frames put their checksum at index 2.
  function automatic logic [7:0] frame_byte(input rsp_frame_t f,
                                            input logic [1:0] idx,
                                            input logic [7:0] sof);
    logic [7:0] hdr;
    hdr = {f.typ, f.addr};
    case (idx)
      2'd0:    return sof;
      2'd1:    return hdr;
      2'd2:    return (f.typ == RSP_RD) ? f.data : hdr;
      default: return hdr ^ f.data;
    endcase
  endfunction

endpackage

// File: rtl/resp_hold_slot.sv
// One-entry pending response slot with sticky overflow flag.
module resp_hold_slot
  import resp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  rsp_frame_t load_frame,
  input  logic       pop,
  input  logic       drop,
  input  logic       ovf_clr,
  output logic       full,
  output rsp_frame_t frame,
  output logic       ovf
);

  logic accept;
  logic ovf_set;

  // A pop in the same cycle frees the entry, so a full slot can still take a load.
  assign accept  = load && (!full || pop);
  assign ovf_set = drop || (load && full && !pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      full  <= 1'b0;
      frame <= '0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        frame <= load_frame;
        full  <= 1'b1;
      end else if (pop) begin
        full  <= 1'b0;
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/resp_tx_framer.sv
// Builds read/write response frames from register-file completions and feeds
// them byte by byte to uart_tx over a start/busy handshake.
module resp_tx_framer
  import resp_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
  parameter int         ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              resp_busy,
  output logic              ovf,
  input  logic              ovf_clr
);

  resp_state_e state_q, state_d;
  rsp_frame_t  active_q, ev_frame, slot_frame;
  logic        active_valid;
  logic [1:0]  byte_idx;
  logic        ev_valid, capture_active, slot_load, slot_pop, slot_full;
  logic        at_last;

  // A simultaneous read and write keeps the read; the write is reported as dropped.
  always_comb begin
    ev_frame = '0;
    if (rd_valid) begin
      ev_frame.typ  = RSP_RD;
      ev_frame.addr = 6'(rd_addr);
      ev_frame.data = rd_data;
    end else begin
      ev_frame.typ  = RSP_WR;
      ev_frame.addr = 6'(wr_addr);
    end
  end

  assign ev_valid       = rd_valid | wr_valid;
  assign capture_active = ev_valid && (state_q == IDLE) && !active_valid && !slot_full;
  assign slot_load      = ev_valid && !capture_active;
  assign at_last        = (byte_idx == last_idx(active_q.typ));

  resp_hold_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (slot_load),
    .load_frame (ev_frame),
    .pop        (slot_pop),
    .drop       (rd_valid & wr_valid),
    .ovf_clr    (ovf_clr),
    .full       (slot_full),
    .frame      (slot_frame),
    .ovf        (ovf)
  );

  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    slot_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (active_valid)   state_d  = LOAD;
        else if (slot_full) slot_pop = 1'b1;
      end
      LOAD: state_d = SEND;
      SEND: begin
        if (!tx_busy) begin
          tx_start = reset;
          state_d  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) state_d = at_last ? FINISH : SEND;
      end
      FINISH: begin
        if (slot_full) begin
          slot_pop = 1'b1;
          state_d  = LOAD;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      active_q     <= '0;
      active_valid <= 1'b0;
      byte_idx     <= 2'd0;
      tx_data      <= 8'h00;
    end else begin
      state_q <= state_d;
      if (capture_active) begin
        active_q     <= ev_frame;
        active_valid <= 1'b1;
      end else if (slot_pop) begin
        active_q     <= slot_frame;
        active_valid <= 1'b1;
      end else if (state_q == LOAD) begin
        active_valid <= 1'b0;
      end
      // tx_data only moves in LOAD or once uart_tx has released the byte.
      if (state_q == LOAD) begin
        byte_idx <= 2'd0;
        tx_data  <= frame_byte(active_q, 2'd0, SOF_BYTE);
      end else if (state_q == WAIT_DONE && !tx_busy && !at_last) begin
        byte_idx <= byte_idx + 2'd1;
        tx_data  <= frame_byte(active_q, byte_idx + 2'd1, SOF_BYTE);
      end
    end
  end

  assign resp_busy = (state_q != IDLE) | slot_full | active_valid;

endmodule
